ntt_stage_scheduler: RTL and testbench
======================================

Name: ntt_stage_scheduler

Overview:
- Sequences one full NTT pass over the 16-bank memory by driving the address generator top's enable and consuming its per-cycle bundles of 16 bank/memory-address pairs.
- Buffers the bundles, then issues bank read requests.
- Replays each address bundle as a write-back after the fixed butterfly pipeline latency.
- Prevents read-after-write hazards across stage boundaries: a stage's reads stall until all writes of the previous stage have retired.
- Sits between the host control FSM, the AGU top, and the bank memory arbiter.

Parameters:
- MA_W, 8, width of one memory-address index.
- BN_W, 4, width of one bank index.
- FIFO_DEPTH, 16, bundle buffer depth; power of two, at least 4.
- PIPE_LAT, 10, cycles from rd_en to matching wr_en (memory read + butterfly latency); at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle request to run a pass; ignored while busy
- agu_enable  out  1  AGU run enable
- agu_out_en  in  1  bundle valid from AGU top
- agu_ma  in  16*MA_W  packed MA0..MA15 (MA0 in LSBs)
- agu_bn  in  16*BN_W  packed BN0..BN15
- agu_l  in  3  stage index of the bundle
- agu_done  in  1  AGU finished all stages
- rd_en  out  1  read bundle strobe
- rd_ma  out  16*MA_W  read addresses
- rd_bn  out  16*BN_W  read banks
- rd_l  out  3  read stage
- wr_en  out  1  write-back strobe
- wr_ma  out  16*MA_W  write addresses
- wr_bn  out  16*BN_W  write banks
- wr_l  out  3  write stage
- stall  out  1  head bundle held by stage hazard
- busy  out  1  pass in progress
- done  out  1  one-cycle pass-complete pulse
- ovf_err  out  1  sticky: bundle dropped on full FIFO

Behaviour:
- Reset: all outputs 0, FSM IDLE, FIFO empty, inflight=0, cur_l=0, delay line cleared. Reset mid-pass aborts silently: no done pulse, and no wr_en until the next pass.
- FSM states:
  - IDLE: on start, go to RUN; clear ovf_err and cur_l; busy=1 from the next cycle.
  - RUN: agu_enable=1. When agu_done is sampled high, latch it and go to DRAIN; agu_enable=0 from the next cycle. A bundle arriving in the same cycle as agu_done is still accepted.
  - DRAIN: continue popping and writing. When FIFO empty AND inflight==0 AND delay line empty, go to DONE.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Push: agu_out_en=1 in RUN or DRAIN writes {ma,bn,l} to the FIFO.
  - If full and no pop in the same cycle: drop the bundle and set ovf_err.
  - If full with a simultaneous pop: accept the push.
  - agu_out_en is ignored in IDLE.
- Pop when FIFO not empty and NOT hazard, where hazard = (head.l != cur_l) && (inflight != 0).
  - stall = !empty && hazard (combinational).
  - On pop: rd_en and the rd_* signals are registered (valid the cycle after the pop decision); cur_l <= head.l; inflight++.
  - First-bundle latency: agu_out_en to rd_en is 2 cycles with an empty FIFO.
- Write-back: each pop enters a PIPE_LAT-deep shift register of {ma,bn,l,valid}; wr_en and wr_* assert exactly PIPE_LAT cycles after the matching rd_en.
  - inflight decrements on wr_en; a pop and a write in the same cycle leave it unchanged.
- inflight width is clog2(PIPE_LAT+1). It never exceeds PIPE_LAT; a value above that is an assertion failure.
- FIFO pointers are one bit wider than the index for the full/empty distinction and wrap modulo 2*FIFO_DEPTH.
- rd_* and wr_* hold their last values while the corresponding enable is low.
- start during busy has no effect.

Test Plan:
- Single stage, 4 bundles, l=0 back-to-back, PIPE_LAT=10:
  - rd_en at cycles T+2..T+5; wr_en at T+12..T+15 with identical addresses.
  - done 1 cycle after the last wr_en plus DRAIN exit; stall never high.
- Stage change: 3 bundles l=0 then 1 bundle l=1 on the next cycle:
  - l=1 bundle held with stall=1 until the third l=0 wr_en.
  - Its rd_en follows 1 cycle after that wr_en; rd_l=1.
- Overflow, FIFO_DEPTH=4: force a hazard stall and push 6 bundles:
  - bundles 5 and 6 are dropped; ovf_err=1 and stays set through done.
  - ovf_err clears on the next start.
- Full FIFO with simultaneous push and pop: bundle accepted, no ovf_err, order preserved (rd_ma sequence equals push sequence).
- agu_done in the same cycle as the last agu_out_en: that bundle is read and written; done pulses exactly once; start during busy ignored.
- Async rst asserted mid-DRAIN with inflight=5: all outputs 0 immediately; no wr_en or done afterwards; the next start runs cleanly.

Source files
------------

// File: rtl/ntt_stage_scheduler_if.sv
// Signal bundle between the NTT stage scheduler and its host, AGU and bank arbiter.
// The scheduler uses the master modport; the environment uses the slave modport.
interface ntt_stage_scheduler_if #(
  parameter int MA_W = 8,
  parameter int BN_W = 4
);
  logic               start;
  logic               agu_enable;
  logic               agu_out_en;
  logic [16*MA_W-1:0] agu_ma;
  logic [16*BN_W-1:0] agu_bn;
  logic [2:0]         agu_l;
  logic               agu_done;
  logic               rd_en;
  logic [16*MA_W-1:0] rd_ma;
  logic [16*BN_W-1:0] rd_bn;
  logic [2:0]         rd_l;
  logic               wr_en;
  logic [16*MA_W-1:0] wr_ma;
  logic [16*BN_W-1:0] wr_bn;
  logic [2:0]         wr_l;
  logic               stall;
  logic               busy;
  logic               done;
  logic               ovf_err;

  modport master (
    input  start, agu_out_en, agu_ma, agu_bn, agu_l, agu_done,
    output agu_enable, rd_en, rd_ma, rd_bn, rd_l, wr_en, wr_ma, wr_bn, wr_l,
           stall, busy, done, ovf_err
  );

  modport slave (
    output start, agu_out_en, agu_ma, agu_bn, agu_l, agu_done,
    input  agu_enable, rd_en, rd_ma, rd_bn, rd_l, wr_en, wr_ma, wr_bn, wr_l,
           stall, busy, done, ovf_err
  );
endinterface

// File: rtl/ntt_stage_scheduler.sv
// Runs one NTT pass: buffers AGU address bundles, issues bank reads, replays them as
// write-backs after the butterfly latency, and holds a new stage's reads until the old stage retires.
module ntt_stage_scheduler #(
  parameter int MA_W       = 8,
  parameter int BN_W       = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int PIPE_LAT   = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  ntt_stage_scheduler_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int IW = $clog2(PIPE_LAT + 1);

  typedef struct packed {
    logic [16*MA_W-1:0] ma;
    logic [16*BN_W-1:0] bn;
    logic [2:0]         l;
  } bundle_t;

  typedef struct packed {
    logic    vld;
    bundle_t b;
  } slot_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  bundle_t       mem_q [FIFO_DEPTH];
  bundle_t       mem_d [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic [2:0]    cur_l_q, cur_l_d;
  slot_t         dl_q [PIPE_LAT];
  slot_t         dl_d [PIPE_LAT];
  logic          rd_en_q, rd_en_d;
  bundle_t       rd_q, rd_d;
  logic          wr_en_q, wr_en_d;
  bundle_t       wr_q, wr_d;
  logic          agu_enable_q, agu_enable_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;

  logic          empty_s, full_s, hazard_s, pop_s;
  logic          accept_s, push_s, drop_s, retire_s, dl_busy_s;
  bundle_t       head_s, in_s;

  // FIFO status and the stage-boundary hazard that gates popping
  always_comb begin
    in_s      = {bus.agu_ma, bus.agu_bn, bus.agu_l};
    empty_s   = (wptr_q == rptr_q);
    full_s    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    head_s    = mem_q[rptr_q[AW-1:0]];
    hazard_s  = (head_s.l != cur_l_q) && (inflight_q != '0);
    pop_s     = !empty_s && !hazard_s;
    accept_s  = bus.agu_out_en && ((state_q == S_RUN) || (state_q == S_DRAIN));
    // A full FIFO still takes the bundle when a slot frees in the same cycle
    push_s    = accept_s && (!full_s || pop_s);
    drop_s    = accept_s && full_s && !pop_s;
    retire_s  = dl_q[PIPE_LAT-1].vld;
    dl_busy_s = 1'b0;
    for (int i = 0; i < PIPE_LAT; i++) begin
      dl_busy_s = dl_busy_s | dl_q[i].vld;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_RUN;
        else           state_d = S_IDLE;
      end
      S_RUN: begin
        if (bus.agu_done) state_d = S_DRAIN;
        else              state_d = S_RUN;
      end
      S_DRAIN: begin
        // A late bundle landing this cycle keeps the pass open
        if (empty_s && (inflight_q == '0) && !dl_busy_s && !push_s) state_d = S_DONE;
        else                                                        state_d = S_DRAIN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    agu_enable_d = (state_d == S_RUN);
    busy_d       = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d       = (state_d == S_DONE);
  end

  always_comb begin
    mem_d = mem_q;
    if (push_s) begin
      mem_d[wptr_q[AW-1:0]] = in_s;
      wptr_d = wptr_q + PW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) rptr_d = rptr_q + PW'(1);
    else       rptr_d = rptr_q;

    case ({pop_s, retire_s})
      2'b10:   inflight_d = inflight_q + IW'(1);
      2'b01:   inflight_d = inflight_q - IW'(1);
      default: inflight_d = inflight_q;
    endcase

    if ((state_q == S_IDLE) && bus.start) cur_l_d = 3'd0;
    else if (pop_s)                       cur_l_d = head_s.l;
    else                                  cur_l_d = cur_l_q;

    if ((state_q == S_IDLE) && bus.start) ovf_d = 1'b0;
    else if (drop_s)                      ovf_d = 1'b1;
    else                                  ovf_d = ovf_q;

    if (pop_s) dl_d[0] = {1'b1, head_s};
    else       dl_d[0] = '0;
    for (int i = 1; i < PIPE_LAT; i++) begin
      dl_d[i] = dl_q[i-1];
    end

    rd_en_d = pop_s;
    if (pop_s) rd_d = head_s;
    else       rd_d = rd_q;
    wr_en_d = retire_s;
    if (retire_s) wr_d = dl_q[PIPE_LAT-1].b;
    else          wr_d = wr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      for (int i = 0; i < PIPE_LAT; i++)   dl_q[i]  <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      inflight_q   <= '0;
      cur_l_q      <= 3'd0;
      rd_en_q      <= 1'b0;
      rd_q         <= '0;
      wr_en_q      <= 1'b0;
      wr_q         <= '0;
      agu_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
      for (int i = 0; i < PIPE_LAT; i++)   dl_q[i]  <= dl_d[i];
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      inflight_q   <= inflight_d;
      cur_l_q      <= cur_l_d;
      rd_en_q      <= rd_en_d;
      rd_q         <= rd_d;
      wr_en_q      <= wr_en_d;
      wr_q         <= wr_d;
      agu_enable_q <= agu_enable_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
    end
  end

  assign bus.agu_enable = agu_enable_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.rd_ma      = rd_q.ma;
  assign bus.rd_bn      = rd_q.bn;
  assign bus.rd_l       = rd_q.l;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_ma      = wr_q.ma;
  assign bus.wr_bn      = wr_q.bn;
  assign bus.wr_l       = wr_q.l;
  assign bus.stall      = !empty_s && hazard_s;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.ovf_err    = ovf_q;

  // The write-back pipe can never hold more bundles than its depth
  a_inflight_max: assert property (@(posedge clk) disable iff (rst) inflight_q <= IW'(PIPE_LAT));

endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// Directed bench for ntt_stage_scheduler with a 4-deep bundle FIFO and a 10-cycle write-back latency.
module tb_ntt_stage_scheduler;
  localparam int MA_W       = 8;
  localparam int BN_W       = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int PIPE_LAT   = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  ntt_stage_scheduler_if #(.MA_W(MA_W), .BN_W(BN_W)) ifc ();

  ntt_stage_scheduler #(
    .MA_W(MA_W), .BN_W(BN_W), .FIFO_DEPTH(FIFO_DEPTH), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                 cyc;
    logic [16*MA_W-1:0] ma;
    logic [16*BN_W-1:0] bn;
    logic [2:0]         l;
  } ev_t;

  ev_t  rdq[$];
  ev_t  wrq[$];
  int   doneq[$];
  int   stallq[$];
  logic done_ovf[$];

  // Event log sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.rd_en) rdq.push_back('{cyc, ifc.rd_ma, ifc.rd_bn, ifc.rd_l});
      if (ifc.wr_en) wrq.push_back('{cyc, ifc.wr_ma, ifc.wr_bn, ifc.wr_l});
      if (ifc.stall) stallq.push_back(cyc);
      if (ifc.done) begin
        doneq.push_back(cyc);
        done_ovf.push_back(ifc.ovf_err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [16*MA_W-1:0] make_ma(input int id);
    logic [16*MA_W-1:0] v;
    for (int i = 0; i < 16; i++) v[i*MA_W +: MA_W] = MA_W'(id * 16 + i);
    return v;
  endfunction

  function automatic logic [16*BN_W-1:0] make_bn(input int id);
    logic [16*BN_W-1:0] v;
    for (int i = 0; i < 16; i++) v[i*BN_W +: BN_W] = BN_W'(id + i);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rdq.delete(); wrq.delete(); doneq.delete(); stallq.delete(); done_ovf.delete();
  endtask

  task automatic start_pass();
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
  endtask

  task automatic drive(input int id, input logic [2:0] l, input logic last);
    ifc.agu_out_en = 1'b1;
    ifc.agu_ma     = make_ma(id);
    ifc.agu_bn     = make_bn(id);
    ifc.agu_l      = l;
    ifc.agu_done   = last;
    tick();
    ifc.agu_out_en = 1'b0;
    ifc.agu_done   = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (doneq.size() == 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (doneq.size() == 0) begin
      errors++;
      $display("FAIL wait_done: no done pulse within %0d cycles", budget);
    end
    tick();
  endtask

  task automatic test_reset();
    ifc.start = 1'b0; ifc.agu_out_en = 1'b0; ifc.agu_done = 1'b0;
    ifc.agu_ma = '0; ifc.agu_bn = '0; ifc.agu_l = 3'd0;
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({ifc.agu_enable, ifc.rd_en, ifc.wr_en, ifc.stall, ifc.busy, ifc.done, ifc.ovf_err} !== 7'd0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {ifc.agu_enable, ifc.rd_en, ifc.wr_en, ifc.stall, ifc.busy, ifc.done, ifc.ovf_err});
    end
    checks++;
    if (ifc.rd_ma !== '0 || ifc.wr_ma !== '0 || ifc.rd_l !== 3'd0 || ifc.wr_l !== 3'd0) begin
      errors++;
      $display("FAIL reset_data: rd_ma=%h wr_ma=%h expected zero", ifc.rd_ma, ifc.wr_ma);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_stage();
    int t0;
    clear_logs();
    start_pass();
    checks++;
    if (ifc.busy !== 1'b1 || ifc.agu_enable !== 1'b1) begin
      errors++;
      $display("FAIL single_busy: busy=%b agu_enable=%b expected 1 1", ifc.busy, ifc.agu_enable);
    end
    t0 = cyc;
    for (int i = 0; i < 4; i++) drive(i, 3'd0, i == 3);
    wait_done(40);
    checks++;
    if (rdq.size() != 4 || wrq.size() != 4) begin
      errors++;
      $display("FAIL single_count: rd=%0d wr=%0d expected 4 4", rdq.size(), wrq.size());
    end
    for (int i = 0; i < 4 && i < rdq.size(); i++) begin
      checks++;
      if (rdq[i].cyc != t0 + 2 + i || rdq[i].ma !== make_ma(i) || rdq[i].bn !== make_bn(i) || rdq[i].l !== 3'd0) begin
        errors++;
        $display("FAIL single_rd%0d: cyc=%0d ma=%h l=%0d expected cyc=%0d ma=%h l=0",
                 i, rdq[i].cyc - t0, rdq[i].ma, rdq[i].l, 2 + i, make_ma(i));
      end
    end
    for (int i = 0; i < 4 && i < wrq.size(); i++) begin
      checks++;
      if (wrq[i].cyc != t0 + 12 + i || wrq[i].ma !== make_ma(i) || wrq[i].bn !== make_bn(i) || wrq[i].l !== 3'd0) begin
        errors++;
        $display("FAIL single_wr%0d: cyc=%0d ma=%h expected cyc=%0d ma=%h",
                 i, wrq[i].cyc - t0, wrq[i].ma, 12 + i, make_ma(i));
      end
    end
    checks++;
    if (doneq.size() != 1 || doneq[0] != t0 + 16) begin
      errors++;
      $display("FAIL single_done: count=%0d cyc=%0d expected count=1 cyc=16",
               doneq.size(), (doneq.size() > 0) ? doneq[0] - t0 : -1);
    end
    checks++;
    if (stallq.size() != 0 || ifc.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_stall_busy: stalls=%0d busy=%b expected 0 0", stallq.size(), ifc.busy);
    end
  endtask

  task automatic test_stage_change();
    int t0;
    clear_logs();
    start_pass();
    t0 = cyc;
    for (int i = 0; i < 3; i++) drive(10 + i, 3'd0, 1'b0);
    drive(13, 3'd1, 1'b1);
    wait_done(50);
    checks++;
    if (stallq.size() != 10 || stallq[0] != t0 + 4 || stallq[stallq.size()-1] != t0 + 13) begin
      errors++;
      $display("FAIL stage_stall: n=%0d first=%0d last=%0d expected n=10 first=4 last=13",
               stallq.size(), (stallq.size() > 0) ? stallq[0] - t0 : -1,
               (stallq.size() > 0) ? stallq[stallq.size()-1] - t0 : -1);
    end
    checks++;
    if (rdq.size() != 4 || wrq.size() != 4) begin
      errors++;
      $display("FAIL stage_count: rd=%0d wr=%0d expected 4 4", rdq.size(), wrq.size());
    end else begin
      checks++;
      if (wrq[2].cyc != t0 + 14 || rdq[3].cyc != t0 + 15 || rdq[3].l !== 3'd1 || rdq[3].ma !== make_ma(13)) begin
        errors++;
        $display("FAIL stage_l1_read: wr2=%0d rd3=%0d rd_l=%0d expected wr2=14 rd3=15 rd_l=1",
                 wrq[2].cyc - t0, rdq[3].cyc - t0, rdq[3].l);
      end
      checks++;
      if (wrq[3].cyc != t0 + 25 || wrq[3].l !== 3'd1 || wrq[3].ma !== make_ma(13)) begin
        errors++;
        $display("FAIL stage_l1_write: cyc=%0d wr_l=%0d expected cyc=25 wr_l=1", wrq[3].cyc - t0, wrq[3].l);
      end
    end
  endtask

  task automatic test_overflow();
    int t0;
    int ids[5] = '{20, 21, 22, 23, 24};
    int cys[5] = '{2, 13, 14, 15, 16};
    clear_logs();
    start_pass();
    t0 = cyc;
    drive(20, 3'd0, 1'b0);
    for (int i = 1; i <= 6; i++) drive(20 + i, 3'd1, i == 6);
    checks++;
    if (ifc.ovf_err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: ovf_err=%b expected 1", ifc.ovf_err);
    end
    wait_done(50);
    checks++;
    if (rdq.size() != 5) begin
      errors++;
      $display("FAIL ovf_rd_count: got %0d expected 5", rdq.size());
    end
    for (int i = 0; i < 5 && i < rdq.size(); i++) begin
      checks++;
      if (rdq[i].cyc != t0 + cys[i] || rdq[i].ma !== make_ma(ids[i])) begin
        errors++;
        $display("FAIL ovf_rd%0d: cyc=%0d ma=%h expected cyc=%0d ma=%h",
                 i, rdq[i].cyc - t0, rdq[i].ma, cys[i], make_ma(ids[i]));
      end
    end
    checks++;
    if (doneq.size() != 1 || doneq[0] != t0 + 27 || done_ovf[0] !== 1'b1 || ifc.ovf_err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_done: done_cyc=%0d ovf_at_done=%b ovf_now=%b expected 27 1 1",
               (doneq.size() > 0) ? doneq[0] - t0 : -1, (done_ovf.size() > 0) ? done_ovf[0] : 1'bx, ifc.ovf_err);
    end
    clear_logs();
    start_pass();
    checks++;
    if (ifc.ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: ovf_err=%b expected 0", ifc.ovf_err);
    end
    ifc.agu_done = 1'b1;
    tick();
    ifc.agu_done = 1'b0;
    wait_done(20);
  endtask

  task automatic test_full_push_pop();
    int t0;
    int cys[8] = '{2, 13, 14, 15, 16, 17, 18, 19};
    clear_logs();
    start_pass();
    t0 = cyc;
    drive(30, 3'd0, 1'b0);
    for (int i = 1; i <= 4; i++) drive(30 + i, 3'd1, 1'b0);
    repeat (7) tick();
    for (int i = 5; i <= 7; i++) drive(30 + i, 3'd1, i == 7);
    wait_done(50);
    checks++;
    if (rdq.size() != 8 || stallq.size() != 10) begin
      errors++;
      $display("FAIL full_count: rd=%0d stalls=%0d expected 8 10", rdq.size(), stallq.size());
    end
    for (int i = 0; i < 8 && i < rdq.size(); i++) begin
      checks++;
      if (rdq[i].cyc != t0 + cys[i] || rdq[i].ma !== make_ma(30 + i)) begin
        errors++;
        $display("FAIL full_rd%0d: cyc=%0d ma=%h expected cyc=%0d ma=%h",
                 i, rdq[i].cyc - t0, rdq[i].ma, cys[i], make_ma(30 + i));
      end
    end
    checks++;
    if (done_ovf.size() != 1 || done_ovf[0] !== 1'b0) begin
      errors++;
      $display("FAIL full_no_ovf: done_count=%0d ovf_at_done=%b expected 1 0",
               done_ovf.size(), (done_ovf.size() > 0) ? done_ovf[0] : 1'bx);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    clear_logs();
    start_pass();
    t0 = cyc;
    drive(40, 3'd0, 1'b0);
    drive(41, 3'd0, 1'b1);
    checks++;
    if (ifc.agu_enable !== 1'b0 || ifc.busy !== 1'b1) begin
      errors++;
      $display("FAIL btb_enable_drop: agu_enable=%b busy=%b expected 0 1", ifc.agu_enable, ifc.busy);
    end
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    wait_done(40);
    repeat (15) tick();
    checks++;
    if (rdq.size() != 2 || wrq.size() != 2) begin
      errors++;
      $display("FAIL btb_count: rd=%0d wr=%0d expected 2 2", rdq.size(), wrq.size());
    end else begin
      checks++;
      if (rdq[1].cyc != t0 + 3 || wrq[1].cyc != t0 + 13 || wrq[1].ma !== make_ma(41)) begin
        errors++;
        $display("FAIL btb_last: rd=%0d wr=%0d ma=%h expected rd=3 wr=13 ma=%h",
                 rdq[1].cyc - t0, wrq[1].cyc - t0, wrq[1].ma, make_ma(41));
      end
    end
    checks++;
    if (doneq.size() != 1 || doneq[0] != t0 + 14 || ifc.busy !== 1'b0 || ifc.agu_enable !== 1'b0) begin
      errors++;
      $display("FAIL btb_done_once: count=%0d busy=%b agu_enable=%b expected 1 0 0",
               doneq.size(), ifc.busy, ifc.agu_enable);
    end
  endtask

  task automatic test_reset_mid_drain();
    int t0;
    clear_logs();
    start_pass();
    t0 = cyc;
    for (int i = 0; i < 5; i++) drive(50 + i, 3'd0, i == 4);
    tick();
    checks++;
    if (ifc.rd_en !== 1'b1 || ifc.busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: rd_en=%b busy=%b expected 1 1", ifc.rd_en, ifc.busy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({ifc.agu_enable, ifc.rd_en, ifc.wr_en, ifc.stall, ifc.busy, ifc.done, ifc.ovf_err} !== 7'd0 ||
        ifc.rd_ma !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: flags=%b rd_ma=%h expected 0000000 zero",
               {ifc.agu_enable, ifc.rd_en, ifc.wr_en, ifc.stall, ifc.busy, ifc.done, ifc.ovf_err}, ifc.rd_ma);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_logs();
    repeat (30) tick();
    checks++;
    if (wrq.size() != 0 || doneq.size() != 0 || rdq.size() != 0) begin
      errors++;
      $display("FAIL rstmid_quiet: wr=%0d done=%0d rd=%0d expected 0 0 0", wrq.size(), doneq.size(), rdq.size());
    end
    clear_logs();
    start_pass();
    t0 = cyc;
    drive(60, 3'd2, 1'b1);
    wait_done(30);
    checks++;
    if (rdq.size() != 1 || wrq.size() != 1 || doneq.size() != 1) begin
      errors++;
      $display("FAIL rstmid_rerun_count: rd=%0d wr=%0d done=%0d expected 1 1 1", rdq.size(), wrq.size(), doneq.size());
    end else begin
      checks++;
      if (rdq[0].cyc != t0 + 2 || wrq[0].cyc != t0 + 12 || wrq[0].ma !== make_ma(60) ||
          wrq[0].l !== 3'd2 || doneq[0] != t0 + 13) begin
        errors++;
        $display("FAIL rstmid_rerun: rd=%0d wr=%0d l=%0d done=%0d expected 2 12 2 13",
                 rdq[0].cyc - t0, wrq[0].cyc - t0, wrq[0].l, doneq[0] - t0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_stage();
    test_stage_change();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
